result_streamer: RTL and testbench

// - Reader/unloader for the 18-bit product memory (mat3, memory18) filled by the multiply-accumulate datapath.
// - On start: reads every result word in linear address order.
// - Splits each word into DATA_WIDTH-bit chunks and streams them out on a valid/ready byte interface.
// - Sits between mat3's read port and the host/output side; owns mat3's address and enables while busy.

---
 rtl/result_pkg.sv | 7 +
 rtl/chunk_select.sv | 14 +
 rtl/result_streamer.sv | 101 ++++++++++
 tb/tb_result_streamer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_pkg.sv
// result_pkg: shared widths, chunk count and FSM state encoding for the result unloader
package result_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int RES_WIDTH = 2 * DATA_WIDTH + 2;
  localparam int CHUNKS = (RES_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_e;
endpackage

// File: rtl/chunk_select.sv
// chunk_select: picks the DATA_WIDTH slice of a held result word, zero-extending the top chunk
module chunk_select #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH = 18
) (
  input  logic [RES_WIDTH-1:0]  hold_i,
  input  logic [1:0]            shift_i,
  output logic [DATA_WIDTH-1:0] chunk_o
);
  // widened to four chunks so every 2-bit index selects in range
  logic [4*DATA_WIDTH-1:0] ext;
  assign ext = (4*DATA_WIDTH)'(hold_i);
  assign chunk_o = ext[int'(shift_i)*DATA_WIDTH +: DATA_WIDTH];
endmodule

// File: rtl/result_streamer.sv
// result_streamer: reads every mat3 result word in address order and streams it
// out LS chunk first over a valid/ready interface
module result_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH = 18,
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  m3EN,
  output logic                  m3rEN,
  output logic                  m3wEN,
  output logic [ADDR_WIDTH-1:0] addr3,
  input  logic [RES_WIDTH-1:0]  result,
  output logic [1:0]            shift_cnt,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  input  logic                  out_ready
);
  import result_pkg::*;
  localparam int NCH = (RES_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] word_q, addr_q;
  logic [RES_WIDTH-1:0]  hold_q;
  logic [1:0]            shift_q;
  logic                  busy_q, done_q, m3en_q, valid_q;
  logic                  last_word, last_chunk;
  assign last_word = word_q == ADDR_WIDTH'(ROWS * COLS - 1);
  assign last_chunk = shift_q == 2'(NCH - 1);
  // outputs are registered alongside the state they belong to
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      addr_q  <= '0;
      hold_q  <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      m3en_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      m3en_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= READ;
          word_q  <= '0;
          addr_q  <= '0;
          busy_q  <= 1'b1;
          m3en_q  <= 1'b1;
        end
        READ: state_q <= WAIT;
        WAIT: begin
          hold_q  <= result;
          shift_q <= '0;
          valid_q <= 1'b1;
          state_q <= SEND;
        end
        SEND: if (out_ready) begin
          if (last_chunk) begin
            valid_q <= 1'b0;
            shift_q <= '0;
            if (last_word) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              word_q  <= word_q + 1'b1;
              addr_q  <= word_q + 1'b1;
              m3en_q  <= 1'b1;
              state_q <= READ;
            end
          end else shift_q <= shift_q + 1'b1;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  chunk_select #(.DATA_WIDTH(DATA_WIDTH), .RES_WIDTH(RES_WIDTH)) u_sel (
    .hold_i (hold_q),
    .shift_i(shift_q),
    .chunk_o(data_out)
  );
  assign busy = busy_q;
  assign done = done_q;
  assign m3EN = m3en_q;
  assign m3rEN = m3en_q;
  assign m3wEN = 1'b0;
  assign addr3 = addr_q;
  assign shift_cnt = shift_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_result_streamer.sv
// tb_result_streamer: directed tests of the mat3 unloader with a 1-cycle-latency memory model
module tb_result_streamer;
  logic clk = 0, rst = 0, start = 0, start_b = 0, ready = 0, ready_b = 0;
  always #5 clk = ~clk;
  logic busy, done, m3EN, m3rEN, m3wEN, out_valid;
  logic [15:0] addr3;
  logic [17:0] result = '0;
  logic [1:0] shift_cnt;
  logic [7:0] data_out;
  logic busy_b, done_b, m3EN_b, m3rEN_b, m3wEN_b, out_valid_b;
  logic [15:0] addr3_b;
  logic [17:0] result_b = '0;
  logic [1:0] shift_cnt_b;
  logic [7:0] data_out_b;
  result_streamer #(.ROWS(2), .COLS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .m3EN(m3EN),
    .m3rEN(m3rEN), .m3wEN(m3wEN), .addr3(addr3), .result(result), .shift_cnt(shift_cnt),
    .data_out(data_out), .out_valid(out_valid), .out_ready(ready)
  );
  result_streamer #(.ROWS(1), .COLS(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .m3EN(m3EN_b),
    .m3rEN(m3rEN_b), .m3wEN(m3wEN_b), .addr3(addr3_b), .result(result_b), .shift_cnt(shift_cnt_b),
    .data_out(data_out_b), .out_valid(out_valid_b), .out_ready(ready_b)
  );
  logic [17:0] mem [4] = '{18'h3_A5C3, 18'h0_0001, 18'h2_FF00, 18'h1_1234};
  logic [7:0] exp_bytes [12] = '{8'hC3, 8'hA5, 8'h03, 8'h01, 8'h00, 8'h00,
                                 8'h00, 8'hFF, 8'h02, 8'h34, 8'h12, 8'h01};
  always @(posedge clk) if (m3EN && m3rEN) result <= mem[addr3[1:0]];
  always @(posedge clk) if (m3EN_b && m3rEN_b) result_b <= 18'h3_FFFF;
  int checks = 0, failures = 0;
  int cyc = 0, last_hs = 0, done_cyc = 0, done_n = 0;
  int rd_b = 0, busy_b_n = 0, done_b_n = 0;
  bit wen_seen = 0;
  logic [7:0] cap_d[$], cap_b[$];
  logic [1:0] cap_s[$];
  logic [15:0] addrs[$];
  always @(negedge clk) begin
    cyc++;
    if (out_valid && ready) begin
      cap_d.push_back(data_out);
      cap_s.push_back(shift_cnt);
      last_hs = cyc;
    end
    if (m3EN && m3rEN) addrs.push_back(addr3);
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (m3wEN || m3wEN_b) wen_seen = 1;
    if (out_valid_b && ready_b) cap_b.push_back(data_out_b);
    if (m3EN_b && m3rEN_b) rd_b++;
    if (busy_b) busy_b_n++;
    if (done_b) done_b_n++;
  end
  task automatic clear_mon();
    cap_d.delete(); cap_s.delete(); cap_b.delete(); addrs.delete();
    done_n = 0; rd_b = 0; busy_b_n = 0; done_b_n = 0;
  endtask
  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (done_n == 0 && n < 300) begin @(posedge clk); n++; end
    if (done_n == 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout no done within 300 cycles", tag);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic check_stream(input string tag);
    checks++;
    if (cap_d.size() !== 12) begin
      failures++;
      $display("FAIL %s_count got %0d want 12", tag, cap_d.size());
    end
    for (int i = 0; i < 12 && i < cap_d.size(); i++) begin
      checks += 2;
      if (cap_d[i] !== exp_bytes[i]) begin
        failures++;
        $display("FAIL %s_byte%0d got %h want %h", tag, i, cap_d[i], exp_bytes[i]);
      end
      if (cap_s[i] !== 2'(i % 3)) begin
        failures++;
        $display("FAIL %s_shift%0d got %0d want %0d", tag, i, cap_s[i], i % 3);
      end
    end
    checks++;
    if (addrs.size() !== 4) begin
      failures++;
      $display("FAIL %s_reads got %0d want 4", tag, addrs.size());
    end
    for (int i = 0; i < 4 && i < addrs.size(); i++) begin
      checks++;
      if (addrs[i] !== 16'(i)) begin
        failures++;
        $display("FAIL %s_addr%0d got %0d want %0d", tag, i, addrs[i], i);
      end
    end
    checks++;
    if (done_n !== 1) begin
      failures++;
      $display("FAIL %s_done_pulses got %0d want 1", tag, done_n);
    end
  endtask
  task automatic test_reset();
    rst = 0;
    start = 1;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (busy !== 0 || done !== 0) begin
      failures++;
      $display("FAIL reset_busy_done got %b%b want 00", busy, done);
    end
    if (m3EN !== 0 || m3rEN !== 0 || addr3 !== 0) begin
      failures++;
      $display("FAIL reset_mem got en=%b ren=%b addr=%h want 0", m3EN, m3rEN, addr3);
    end
    if (out_valid !== 0 || data_out !== 0 || shift_cnt !== 0) begin
      failures++;
      $display("FAIL reset_stream got v=%b d=%h s=%0d want 0", out_valid, data_out, shift_cnt);
    end
    if (busy_b !== 0) begin
      failures++;
      $display("FAIL reset_busy_b got %b want 0", busy_b);
    end
    start = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 0) begin
      failures++;
      $display("FAIL reset_idle_busy got %b want 0", busy);
    end
  endtask
  task automatic test_full_unload();
    clear_mon();
    ready = 1;
    pulse_start();
    wait_done("full");
    check_stream("full");
    checks += 2;
    if (done_cyc !== last_hs + 1) begin
      failures++;
      $display("FAIL full_done_timing got cycle %0d want %0d", done_cyc, last_hs + 1);
    end
    if (busy !== 0) begin
      failures++;
      $display("FAIL full_busy_after got %b want 0", busy);
    end
  endtask
  task automatic test_backpressure();
    int n = 0;
    clear_mon();
    ready = 0;
    pulse_start();
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    ready = 1;
    @(posedge clk); #1 ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (data_out !== 8'hA5 || shift_cnt !== 2'd1 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold%0d got d=%h s=%0d v=%b want d=a5 s=1 v=1", i, data_out, shift_cnt, out_valid);
      end
    end
    @(posedge clk); #1 ready = 1;
    wait_done("bp");
    check_stream("bp");
  endtask
  task automatic test_start_while_busy();
    int n = 0;
    clear_mon();
    ready = 1;
    pulse_start();
    repeat (3) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    while (!done && n < 300) begin @(posedge clk); #1; n++; end
    start = 1;
    @(posedge clk); #1 start = 0;
    repeat (12) @(posedge clk);
    #1;
    check_stream("busy_start");
    checks++;
    if (busy !== 0) begin
      failures++;
      $display("FAIL busy_start_restart got busy=%b want 0", busy);
    end
  endtask
  task automatic test_single_word();
    int n = 0;
    logic [7:0] exp_b [3] = '{8'hFF, 8'hFF, 8'h03};
    clear_mon();
    ready_b = 1;
    @(posedge clk); #1 start_b = 1;
    @(posedge clk); #1 start_b = 0;
    while (done_b_n == 0 && n < 100) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (cap_b.size() !== 3) begin
      failures++;
      $display("FAIL single_count got %0d want 3", cap_b.size());
    end
    if (busy_b_n !== 6) begin
      failures++;
      $display("FAIL single_busy_cycles got %0d want 6", busy_b_n);
    end
    if (done_b_n !== 1) begin
      failures++;
      $display("FAIL single_done got %0d want 1", done_b_n);
    end
    if (rd_b !== 1) begin
      failures++;
      $display("FAIL single_reads got %0d want 1", rd_b);
    end
    for (int i = 0; i < 3 && i < cap_b.size(); i++) begin
      checks++;
      if (cap_b[i] !== exp_b[i]) begin
        failures++;
        $display("FAIL single_byte%0d got %h want %h", i, cap_b[i], exp_b[i]);
      end
    end
  endtask
  task automatic test_reset_mid_send();
    int n = 0;
    clear_mon();
    ready = 1;
    pulse_start();
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk);
    #2 rst = 0;
    #1;
    checks += 2;
    if ({busy, done, m3EN, m3rEN, addr3, shift_cnt, data_out, out_valid} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got b=%b d=%b en=%b a=%h s=%0d do=%h v=%b want all 0",
               busy, done, m3EN, addr3, shift_cnt, data_out, out_valid);
    end
    if (out_valid !== 0) begin
      failures++;
      $display("FAIL midreset_valid got %b want 0", out_valid);
    end
    @(posedge clk); #1 rst = 1;
    clear_mon();
    pulse_start();
    wait_done("after_reset");
    check_stream("after_reset");
  endtask
  task automatic test_protocol();
    checks++;
    if (wen_seen !== 0) begin
      failures++;
      $display("FAIL protocol_m3wEN got 1 want 0");
    end
  endtask
  initial begin
    test_reset();
    test_full_unload();
    test_backpressure();
    test_start_while_busy();
    test_single_word();
    test_reset_mid_send();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
